// File: rtl/lpc_wb_rx_fifo.sv
// LPC receive FIFO with a Wishbone slave register window and interrupt output.
// Latency: a record is visible in level one cycle after push_i; WB access takes two cycles (ACK on the 2nd).
// Backpressure: none; a push into a full FIFO is dropped and flagged as overflow, a pop from empty flagged as underflow.
module lpc_wb_rx_fifo #(
    parameter int REC_W      = 32,
    parameter int DEPTH_LOG2 = 4,
    parameter int ADR_W      = 17
) (
    input  logic              WB_CLK,
    input  logic              WB_RST,
    input  logic [ADR_W-1:0]  WBs_ADR,
    input  logic              WBs_CYC,
    input  logic              WBs_STB,
    input  logic              WBs_WE,
    input  logic [3:0]        WBs_BYTE_STB,
    input  logic [31:0]       WBs_WR_DAT,
    output logic [31:0]       WBs_RD_DAT,
    output logic              WBs_ACK,
    input  logic              push_i,
    input  logic [REC_W-1:0]  push_data_i,
    output logic              full_o,
    output logic              FPGA_INTR_o
);

    localparam int PTR_W = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [PTR_W-1:0] DEPTH_LVL = PTR_W'(DEPTH);

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_INT    = 2'd3;

    logic [REC_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] level;
    logic             empty;
    logic             full;

    logic [7:0]       thresh;
    logic             ie_lvl;
    logic             ie_ovf;
    logic             ovf;
    logic             unf;
    logic             intr_q;

    logic [1:0]       reg_sel;
    logic             access;
    logic             rd_access;
    logic             wr_access;
    logic             pop;
    logic             unf_set;
    logic             flush;
    logic             push_ok;
    logic             ovf_set;
    logic             int_wr;
    logic             ctrl_wr_lo;
    logic             ctrl_wr_hi;
    logic [31:0]      rd_mux;
    logic [8:0]       level9;
    logic [8:0]       thresh9;
    logic             lvl_hit;
    logic             unused_bits;

    // Address bits outside [3:2] and most write-data bits carry no meaning here.
    assign unused_bits = ^{WBs_ADR, WBs_WR_DAT};

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (level == '0);
    assign full    = (level == DEPTH_LVL);
    assign full_o  = full;
    assign reg_sel = WBs_ADR[3:2];

    // An access is taken on the edge where the strobe is seen with ACK low.
    assign access    = WBs_CYC & WBs_STB & ~WBs_ACK;
    assign rd_access = access & ~WBs_WE;
    assign wr_access = access & WBs_WE;

    assign pop     = rd_access & (reg_sel == REG_DATA) & ~empty;
    assign unf_set = rd_access & (reg_sel == REG_DATA) & empty;

    assign ctrl_wr_lo = wr_access & (reg_sel == REG_CTRL) & WBs_BYTE_STB[0];
    assign ctrl_wr_hi = wr_access & (reg_sel == REG_CTRL) & WBs_BYTE_STB[1];
    assign flush      = ctrl_wr_hi & WBs_WR_DAT[10];
    assign int_wr     = wr_access & (reg_sel == REG_INT) & WBs_BYTE_STB[0];

    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign push_ok = push_i & ~flush & (~full | pop);
    assign ovf_set = push_i & ~flush & full & ~pop;

    // Thresholds above the depth can never be reached by level.
    assign level9  = 9'(level);
    assign thresh9 = {1'b0, thresh};
    assign lvl_hit = ie_lvl & (thresh != 8'd0) & (level9 >= thresh9);

    // Register read multiplexer; unused bits read as zero.
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_DATA: begin
                if (!empty) begin
                    rd_mux[REC_W-1:0] = mem[rd_ptr[DEPTH_LOG2-1:0]];
                end
            end
            REG_STATUS: begin
                rd_mux[PTR_W-1:0] = level;
                rd_mux[16]        = empty;
                rd_mux[17]        = full;
                rd_mux[18]        = ovf;
                rd_mux[19]        = unf;
            end
            REG_CTRL: begin
                rd_mux[7:0] = thresh;
                rd_mux[8]   = ie_lvl;
                rd_mux[9]   = ie_ovf;
            end
            default: begin
                rd_mux[0] = ovf;
                rd_mux[1] = unf;
            end
        endcase
    end

    // Record storage; contents are don't-care after reset so no reset here.
    always_ff @(posedge WB_CLK) begin
        if (push_ok) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data_i;
        end
    end

    // Read/write pointers; flush overrides any push or pop in the same cycle.
    always_ff @(posedge WB_CLK or posedge WB_RST) begin
        if (WB_RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Wishbone handshake: one-cycle ACK with read data valid only in that cycle.
    always_ff @(posedge WB_CLK or posedge WB_RST) begin
        if (WB_RST) begin
            WBs_ACK    <= 1'b0;
            WBs_RD_DAT <= '0;
        end else begin
            WBs_ACK    <= access;
            WBs_RD_DAT <= rd_access ? rd_mux : 32'd0;
        end
    end

    // Control register with per-byte write enables.
    always_ff @(posedge WB_CLK or posedge WB_RST) begin
        if (WB_RST) begin
            thresh <= '0;
            ie_lvl <= 1'b0;
            ie_ovf <= 1'b0;
        end else begin
            if (ctrl_wr_lo) begin
                thresh <= WBs_WR_DAT[7:0];
            end
            if (ctrl_wr_hi) begin
                ie_lvl <= WBs_WR_DAT[8];
                ie_ovf <= WBs_WR_DAT[9];
            end
        end
    end

    // Sticky error flags: write-one-to-clear, with a same-cycle set winning.
    always_ff @(posedge WB_CLK or posedge WB_RST) begin
        if (WB_RST) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            ovf <= ovf_set | (ovf & ~(int_wr & WBs_WR_DAT[0]));
            unf <= unf_set | (unf & ~(int_wr & WBs_WR_DAT[1]));
        end
    end

    // Registered interrupt request.
    always_ff @(posedge WB_CLK or posedge WB_RST) begin
        if (WB_RST) begin
            intr_q <= 1'b0;
        end else begin
            intr_q <= lvl_hit | (ie_ovf & ovf);
        end
    end

    assign FPGA_INTR_o = intr_q;

endmodule

// File: tb/tb_lpc_wb_rx_fifo.sv
// Scoreboard bench for lpc_wb_rx_fifo: directed scenarios followed by random traffic.
// Expected read data is queued at issue time from a queue-based model; a monitor checks every ACK.
// Flags, level and interrupt are derived from the model's queue and sticky bits.
module tb_lpc_wb_rx_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] WBs_ADR;
    logic        WBs_CYC, WBs_STB, WBs_WE;
    logic [3:0]  WBs_BYTE_STB;
    logic [31:0] WBs_WR_DAT;
    logic [31:0] WBs_RD_DAT;
    logic        WBs_ACK;
    logic        push_i;
    logic [31:0] push_data_i;
    logic        full_o;
    logic        FPGA_INTR_o;

    always #5 clk = ~clk;

    lpc_wb_rx_fifo #(.REC_W(32), .DEPTH_LOG2(4), .ADR_W(17)) dut (
        .WB_CLK       (clk),
        .WB_RST       (rst),
        .WBs_ADR      (WBs_ADR),
        .WBs_CYC      (WBs_CYC),
        .WBs_STB      (WBs_STB),
        .WBs_WE       (WBs_WE),
        .WBs_BYTE_STB (WBs_BYTE_STB),
        .WBs_WR_DAT   (WBs_WR_DAT),
        .WBs_RD_DAT   (WBs_RD_DAT),
        .WBs_ACK      (WBs_ACK),
        .push_i       (push_i),
        .push_data_i  (push_data_i),
        .full_o       (full_o),
        .FPGA_INTR_o  (FPGA_INTR_o)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];

    // Reference model state
    logic [31:0] mq[$];
    bit          m_ovf, m_unf, m_ie_lvl, m_ie_ovf;
    logic [7:0]  m_thresh;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_status();
        int n = mq.size();
        return {12'b0, m_unf, m_ovf, (n == DEPTH), (n == 0), 7'b0, 9'(n)};
    endfunction

    function automatic logic m_intr();
        int n = mq.size();
        return (m_ie_lvl && m_thresh != 8'd0 && n >= int'(m_thresh)) || (m_ie_ovf && m_ovf);
    endfunction

    function automatic void m_reset();
        mq.delete();
        m_ovf = 0; m_unf = 0; m_ie_lvl = 0; m_ie_ovf = 0; m_thresh = 8'd0;
    endfunction

    // Monitor: every ACK consumes one expectation; outside ACK read data must be 0.
    always @(negedge clk) begin
        if (WBs_ACK) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack=1 expected no ack at %0t", $time);
            end else begin
                check("rd_dat", WBs_RD_DAT, exp_q.pop_front());
            end
        end else if (!rst) begin
            check("rd_dat_idle", WBs_RD_DAT, 32'd0);
        end
    end

    // One Wishbone access, optionally with push_i asserted on the access edge.
    task automatic wb_access(input bit we, input logic [1:0] r, input logic [31:0] wd,
                             input logic [3:0] be, input bit do_push, input logic [31:0] pd);
        logic [31:0] exp = 32'd0;
        bit popped = 0;
        bit fl = 0;
        int pre = mq.size();
        int n = 0;
        if (!we) begin
            case (r)
                2'd0: begin
                    if (pre > 0) begin exp = mq.pop_front(); popped = 1; end
                    else m_unf = 1;
                end
                2'd1: exp = m_status();
                2'd2: exp = {22'b0, m_ie_ovf, m_ie_lvl, m_thresh};
                default: exp = {30'b0, m_unf, m_ovf};
            endcase
        end else begin
            if (r == 2'd2) begin
                if (be[0]) m_thresh = wd[7:0];
                if (be[1]) begin
                    m_ie_lvl = wd[8];
                    m_ie_ovf = wd[9];
                    if (wd[10]) begin fl = 1; mq.delete(); end
                end
            end else if (r == 2'd3 && be[0]) begin
                if (wd[0]) m_ovf = 0;
                if (wd[1]) m_unf = 0;
            end
        end
        if (do_push && !fl) begin
            if (pre < DEPTH || popped) mq.push_back(pd);
            else m_ovf = 1;
        end
        exp_q.push_back(exp);
        WBs_ADR = {13'b0, r, 2'b00};
        WBs_CYC = 1; WBs_STB = 1; WBs_WE = we;
        WBs_BYTE_STB = be; WBs_WR_DAT = wd;
        push_i = do_push; push_data_i = pd;
        @(negedge clk);
        push_i = 0;
        while (!WBs_ACK && n < 4) begin
            @(negedge clk);
            n++;
        end
        if (!WBs_ACK) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack expected ack within 1 cycle at %0t", $time);
            if (exp_q.size() > 0) void'(exp_q.pop_back());
        end
        @(negedge clk);
        WBs_CYC = 0; WBs_STB = 0; WBs_WE = 0; WBs_BYTE_STB = 4'h0; WBs_WR_DAT = 32'd0;
    endtask

    task automatic rd(input logic [1:0] r);
        wb_access(0, r, 32'd0, 4'h0, 0, 32'd0);
    endtask

    task automatic wr(input logic [1:0] r, input logic [31:0] wd, input logic [3:0] be);
        wb_access(1, r, wd, be, 0, 32'd0);
    endtask

    task automatic push_rec(input logic [31:0] d);
        if (mq.size() < DEPTH) mq.push_back(d);
        else m_ovf = 1;
        push_i = 1; push_data_i = d;
        @(negedge clk);
        push_i = 0;
    endtask

    task automatic check_full();
        check("full_o", {31'b0, full_o}, {31'b0, (mq.size() == DEPTH)});
    endtask

    task automatic check_intr(input string name);
        @(negedge clk);
        @(negedge clk);
        check(name, {31'b0, FPGA_INTR_o}, {31'b0, m_intr()});
    endtask

    task automatic drain();
        while (mq.size() > 0) rd(2'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        WBs_ADR = '0; WBs_CYC = 0; WBs_STB = 0; WBs_WE = 0;
        WBs_BYTE_STB = 4'h0; WBs_WR_DAT = 32'd0;
        push_i = 0; push_data_i = 32'd0;
        m_reset();
        #1;
        check("reset_ack", {31'b0, WBs_ACK}, 32'd0);
        check("reset_rd_dat", WBs_RD_DAT, 32'd0);
        check("reset_intr", {31'b0, FPGA_INTR_o}, 32'd0);
        check("reset_full", {31'b0, full_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        rd(2'd1);
        rd(2'd2);

        // Fill / drain
        for (int i = 0; i < 16; i++) push_rec(32'h100 + i);
        check_full();
        rd(2'd1);
        drain();
        check_full();
        rd(2'd1);

        // Overflow with interrupt enable
        wr(2'd2, 32'h200, 4'b0011);
        for (int i = 0; i < 16; i++) push_rec(32'h200 + i);
        push_rec(32'hDEAD);
        check_intr("ovf_intr");
        rd(2'd1);
        drain();
        rd(2'd0);
        rd(2'd3);
        wr(2'd3, 32'h3, 4'b0001);
        check_intr("ovf_intr_clear");
        rd(2'd1);

        // Level threshold
        wr(2'd2, 32'h104, 4'b0011);
        for (int i = 0; i < 3; i++) push_rec(32'h300 + i);
        check_intr("lvl_below");
        push_rec(32'h303);
        check_intr("lvl_reached");
        rd(2'd0);
        check_intr("lvl_after_pop");
        drain();

        // Simultaneous push and pop on a full FIFO
        wr(2'd2, 32'h0, 4'b0011);
        for (int i = 0; i < 16; i++) push_rec(32'h400 + i);
        wb_access(0, 2'd0, 32'd0, 4'h0, 1, 32'hAA);
        rd(2'd1);
        drain();
        // Push into an empty FIFO while popping it
        wb_access(0, 2'd0, 32'd0, 4'h0, 1, 32'hBB);
        rd(2'd1);
        drain();
        wr(2'd3, 32'h3, 4'b0001);

        // Flush with a concurrent push
        for (int i = 0; i < 5; i++) push_rec(32'h500 + i);
        wb_access(1, 2'd2, 32'h400, 4'b0010, 1, 32'h5FF);
        rd(2'd1);
        rd(2'd2);

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            int op = $urandom_range(0, 9);
            logic [31:0] d = $urandom;
            case (op)
                0, 1, 2: push_rec(d);
                3, 4: rd(2'd0);
                5: rd(2'($urandom_range(0, 3)));
                6: begin
                    logic [31:0] wd = $urandom;
                    if ($urandom_range(0, 9) != 0) wd[10] = 1'b0;
                    wr(2'($urandom_range(0, 3)), wd, 4'($urandom_range(0, 15)));
                end
                7: wr(2'd3, {30'b0, 2'($urandom_range(0, 3))}, 4'($urandom_range(0, 15)));
                8: wb_access(0, 2'd0, 32'd0, 4'h0, 1, d);
                default: for (int j = 0; j < 6; j++) push_rec($urandom);
            endcase
            check_full();
            if (k % 4 == 0) check_intr("rand_intr");
        end
        rd(2'd1);

        // Asynchronous reset during a pending access
        wr(2'd2, 32'h200, 4'b0011);
        for (int i = 0; i < 17; i++) push_rec(32'h600 + i);
        check_intr("pre_reset_intr");
        WBs_ADR = {13'b0, 2'd1, 2'b00};
        WBs_CYC = 1; WBs_STB = 1; WBs_WE = 0;
        #2;
        rst = 1;
        #1;
        check("arst_ack", {31'b0, WBs_ACK}, 32'd0);
        check("arst_rd_dat", WBs_RD_DAT, 32'd0);
        check("arst_intr", {31'b0, FPGA_INTR_o}, 32'd0);
        check("arst_full", {31'b0, full_o}, 32'd0);
        @(negedge clk);
        check("arst_ack_held", {31'b0, WBs_ACK}, 32'd0);
        WBs_CYC = 0; WBs_STB = 0;
        m_reset();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        rd(2'd1);
        rd(2'd2);
        repeat (3) @(negedge clk);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pending_expectations: got %0d left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lpc_wb_rx_fifo.md
LPC_WB_RX_FIFO -- requirements
Module: lpc_wb_rx_fifo

Interface
REQ-001 The block SHALL have parameter REC_W, default 32: LPC cycle record width, legal range 1..32.
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 4: FIFO depth is 2**DEPTH_LOG2, legal range 2..8.
REQ-003 The block SHALL have parameter ADR_W, default 17: Wishbone address width.
REQ-004 The block SHALL have port WB_CLK, input, 1 bit: the single clock for all logic.
REQ-005 The block SHALL have port WB_RST, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port WBs_ADR, input, ADR_W bits: bits [3:2] select the register.
REQ-007 The block SHALL have ports WBs_CYC, WBs_STB and WBs_WE, inputs, 1 bit each: cycle, strobe and write enable.
REQ-008 The block SHALL have port WBs_BYTE_STB, input, 4 bits: write byte enables.
REQ-009 The block SHALL have port WBs_WR_DAT, input, 32 bits: write data.
REQ-010 The block SHALL have port WBs_RD_DAT, output, 32 bits: read data.
REQ-011 The block SHALL have port WBs_ACK, output, 1 bit: transfer acknowledge.
REQ-012 The block SHALL have port push_i, input, 1 bit: record-valid strobe from the LPC decoder, already in the WB_CLK domain.
REQ-013 The block SHALL have port push_data_i, input, REC_W bits: the record.
REQ-014 The block SHALL have port full_o, output, 1 bit: FIFO full.
REQ-015 The block SHALL have port FPGA_INTR_o, output, 1 bit: registered interrupt request.

Function
REQ-016 Registers SHALL be selected by WBs_ADR[3:2]:
- 0 = DATA (RO, read pops)
- 1 = STATUS (RO): [8:0] level, [16] empty, [17] full, [18] ovf, [19] unf
- 2 = CTRL (RW): [7:0] thresh, [8] ie_lvl, [9] ie_ovf, [10] flush (write-only, reads 0)
- 3 = INT (W1C): [0] ovf, [1] unf
REQ-017 WBs_ACK SHALL pulse high for exactly one cycle, the cycle after WBs_CYC&WBs_STB is seen with WBs_ACK low, giving a two-cycle access; back-to-back strobes SHALL ack every other cycle.
REQ-018 WBs_RD_DAT SHALL be valid in the ACK cycle and SHALL be 0 in all other cycles; unused bits SHALL read 0; a DATA record SHALL be zero-extended to 32 bits.
REQ-019 A DATA read with the FIFO non-empty SHALL return the head record and advance the read pointer at the ACK edge.
REQ-020 A DATA read with the FIFO empty SHALL return 0, leave the pointers unchanged, and set unf.
REQ-021 Writes SHALL take effect at the ACK edge and SHALL honour WBs_BYTE_STB per byte; writes to DATA and STATUS SHALL be ignored.
REQ-022 push_i with the FIFO not full SHALL store push_data_i, so level increases by 1 on the next cycle.
REQ-023 push_i with the FIFO full and no pop in the same cycle SHALL drop the record and set ovf; the FIFO contents SHALL be unchanged.
REQ-024 A push and a pop in the same cycle SHALL both be accepted, including when the FIFO is full or empty; on empty the pop SHALL return 0 and set unf while the push is stored.
REQ-025 Pointers SHALL be DEPTH_LOG2+1 bits and wrap naturally; full SHALL be level == 2**DEPTH_LOG2 and empty SHALL be level == 0.
REQ-026 A CTRL write with flush=1 (byte 1 enabled) SHALL zero both pointers on that edge; a push in the same cycle SHALL be dropped without setting ovf; ovf and unf SHALL be unchanged.
REQ-027 An INT write SHALL clear each flag whose bit is 1; a set event in the same cycle SHALL win over the clear.
REQ-028 FPGA_INTR_o SHALL be registered and equal, one cycle after the condition, to (ie_lvl & thresh!=0 & level>=thresh) | (ie_ovf & ovf).
REQ-029 A thresh value greater than the depth SHALL never assert the level interrupt.
REQ-030 full_o SHALL be combinational from the pointers.

Reset
REQ-031 While WB_RST is high, regardless of clock: pointers = 0, thresh = 0, ie_lvl = 0, ie_ovf = 0, ovf = 0, unf = 0, WBs_ACK = 0, WBs_RD_DAT = 0, FPGA_INTR_o = 0, full_o = 0; FIFO RAM contents SHALL be don't-care.
REQ-032 A reset asserted mid-access SHALL abort it with no ACK; the first access after release SHALL complete normally.

Verification
REQ-033 Scenario (fill/drain): with default parameters, push 16 records 0x100..0x10F, then read DATA 16 times -> values 0x100..0x10F in order, full_o high after the 16th push, STATUS=0x10000 at the end.
REQ-034 Scenario (overflow/interrupt): fill 16 records, push 0xDEAD, with ie_ovf=1 -> FPGA_INTR_o high within 2 cycles, STATUS[18]=1, 17th read returns 0 and sets unf; INT write 0x3 -> FPGA_INTR_o low.
REQ-035 Scenario (threshold): CTRL=0x104 (thresh=4, ie_lvl=1), push 3 records -> FPGA_INTR_o low; push a 4th -> FPGA_INTR_o high; one DATA read -> FPGA_INTR_o low.
REQ-036 Scenario (simultaneous push/pop): with the FIFO full, pop and push 0xAA in the same cycle -> level stays 16, ovf stays 0, 0xAA is the last record read out.
REQ-037 Scenario (flush): with 5 records held, write CTRL=0x400 while push_i is high -> level 0, empty 1, ovf 0.
REQ-038 Scenario (async reset): assert WB_RST between clock edges during a pending access -> all outputs 0 immediately, no ACK; a STATUS read after release returns 0x10000.
